// File: rtl/fetch_redirect_controller_pkg.sv
// rtl/fetch_redirect_controller_pkg.sv - shared types for the IF-stage redirect controller
package fetch_redirect_controller_pkg;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    PC_JUMP  = 2'd1,
    PC_REDIR = 2'd2
  } pcsrc_t;

  typedef enum logic [1:0] {
    FC_IDLE  = 2'd0,
    FC_PEND  = 2'd1,
    FC_DRAIN = 2'd2
  } fetchctl_state_t;

  typedef struct packed {
    pcsrc_t      src;
    logic [31:0] target;
  } redir_t;

  localparam redir_t REDIR_NONE = '{src: PC_PLUS4, target: 32'd0};

endpackage

// File: rtl/fetch_redirect_controller_pending.sv
// rtl/fetch_redirect_controller_pending.sv - holding register for a redirect deferred by a fetch stall
module redir_pending_reg
  import fetch_redirect_controller_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   load_i,
  input  logic   clear_i,
  input  redir_t data_i,
  output redir_t data_o
);

  redir_t data_q;

  // Load wins over clear so an overwriting trap is never lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= REDIR_NONE;
    end else if (load_i) begin
      data_q <= data_i;
    end else if (clear_i) begin
      data_q <= REDIR_NONE;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/fetch_redirect_controller.sv
// rtl/fetch_redirect_controller.sv - selects the IF-stage PC source, defers redirects over stalls,
// and runs the FENCE.I refetch drain
module fetch_redirect_controller
  import fetch_redirect_controller_pkg::*;
#(
  parameter int FENCE_DRAIN_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        start_i,
  input  logic        stall_f_i,
  input  logic        trap_redir_valid_i,
  input  logic [31:0] trap_rediraddr_i,
  input  logic        jump_valid_i,
  input  logic [31:0] jump_target_i,
  input  logic        fencei_valid_i,
  input  logic [31:0] fencei_pc_i,
  output pcsrc_t      pcsrc_o,
  output logic [31:0] pc_target_o,
  output logic        flush_req_o,
  output logic        fetch_stall_req_o
);

  localparam logic [3:0] DRAIN_INIT = 4'(FENCE_DRAIN_CYCLES);

  fetchctl_state_t state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [31:0]     refetch_q, refetch_d;
  logic            pend_load, pend_clear;
  redir_t          pend_in, pend_q;
  logic            req_valid;
  redir_t          req;

  redir_pending_reg u_pending (
    .clk_i   (clk_i),
    .rst_ni  (start_i),
    .load_i  (pend_load),
    .clear_i (pend_clear),
    .data_i  (pend_in),
    .data_o  (pend_q)
  );

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    refetch_d         = refetch_q;
    pend_load         = 1'b0;
    pend_clear        = 1'b0;
    pend_in           = REDIR_NONE;
    req_valid         = 1'b0;
    req               = REDIR_NONE;
    pcsrc_o           = PC_PLUS4;
    pc_target_o       = 32'd0;
    flush_req_o       = 1'b0;
    fetch_stall_req_o = 1'b0;

    // trap > fencei > jump; a trap also aborts an in-progress drain.
    if (trap_redir_valid_i) begin
      req_valid = 1'b1;
      req       = '{src: PC_REDIR, target: trap_rediraddr_i};
    end else if (state_q == FC_DRAIN) begin
      fetch_stall_req_o = 1'b1;
      cnt_d             = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        pend_load = 1'b1;
        pend_in   = '{src: PC_JUMP, target: refetch_q};
        state_d   = FC_PEND;
      end
    end else if (fencei_valid_i) begin
      pend_clear  = 1'b1;
      cnt_d       = DRAIN_INIT;
      refetch_d   = fencei_pc_i + 32'd4;
      state_d     = FC_DRAIN;
      flush_req_o = 1'b1;
    end else if (state_q == FC_PEND) begin
      req_valid = 1'b1;
      req       = pend_q;
    end else if (jump_valid_i) begin
      req_valid = 1'b1;
      req       = '{src: PC_JUMP, target: jump_target_i};
    end

    if (req_valid) begin
      cnt_d = 4'd0;
      if (stall_f_i) begin
        pend_load = 1'b1;
        pend_in   = req;
        state_d   = FC_PEND;
      end else begin
        pcsrc_o     = req.src;
        pc_target_o = req.target;
        flush_req_o = 1'b1;
        pend_clear  = 1'b1;
        state_d     = FC_IDLE;
      end
    end

    if (!start_i) begin
      pcsrc_o           = PC_PLUS4;
      pc_target_o       = 32'd0;
      flush_req_o       = 1'b0;
      fetch_stall_req_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state_q   <= FC_IDLE;
      cnt_q     <= 4'd0;
      refetch_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      refetch_q <= refetch_d;
    end
  end

endmodule

// File: tb/tb_fetch_redirect_controller.sv
// tb/tb_fetch_redirect_controller.sv - scoreboard bench for fetch_redirect_controller
module tb_fetch_redirect_controller;
  import fetch_redirect_controller_pkg::*;

  typedef struct {
    pcsrc_t      src;
    logic [31:0] tgt;
    logic        flush;
    logic        fstall;
    logic        chk_tgt;
  } exp_t;

  logic        clk;
  logic        start;
  logic        stall_f;
  logic        trap_v;
  logic [31:0] trap_a;
  logic        jump_v;
  logic [31:0] jump_a;
  logic        fen_v;
  logic [31:0] fen_pc;
  pcsrc_t      pcsrc;
  logic [31:0] pc_target;
  logic        flush_req;
  logic        fetch_stall_req;

  exp_t  sb[$];
  int    n_vec;
  int    n_err;
  string tname;

  fetch_redirect_controller #(.FENCE_DRAIN_CYCLES(4)) dut (
    .clk_i              (clk),
    .start_i            (start),
    .stall_f_i          (stall_f),
    .trap_redir_valid_i (trap_v),
    .trap_rediraddr_i   (trap_a),
    .jump_valid_i       (jump_v),
    .jump_target_i      (jump_a),
    .fencei_valid_i     (fen_v),
    .fencei_pc_i        (fen_pc),
    .pcsrc_o            (pcsrc),
    .pc_target_o        (pc_target),
    .flush_req_o        (flush_req),
    .fetch_stall_req_o  (fetch_stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got 0x%08h expected 0x%08h", tname, tag, got, exp);
    end
  endtask

  task automatic push_exp(input pcsrc_t es, input logic [31:0] et, input logic ef, input logic efs,
                          input logic ct);
    exp_t e;
    e.src = es; e.tgt = et; e.flush = ef; e.fstall = efs; e.chk_tgt = ct;
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk("pcsrc", 32'(pcsrc), 32'(e.src));
    chk("flush", 32'(flush_req), 32'(e.flush));
    chk("fstall", 32'(fetch_stall_req), 32'(e.fstall));
    if (e.chk_tgt) chk("target", pc_target, e.tgt);
  endtask

  // Called on a negedge: drive inputs, push expectation, sample mid-low-phase, advance one cycle.
  task automatic step(input logic st, input logic tv, input logic [31:0] ta, input logic jv,
                      input logic [31:0] ja, input logic fv, input logic [31:0] fp,
                      input pcsrc_t es, input logic [31:0] et, input logic ef, input logic efs);
    stall_f = st; trap_v = tv; trap_a = ta; jump_v = jv; jump_a = ja; fen_v = fv; fen_pc = fp;
    push_exp(es, et, ef, efs, es != PC_PLUS4);
    #2;
    pop_cmp();
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic efs);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, PC_PLUS4, 0, 0, efs);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    start = 1'b0; stall_f = 0; trap_v = 0; trap_a = 0; jump_v = 0; jump_a = 0;
    fen_v = 0; fen_pc = 0;

    tname = "reset";
    @(negedge clk);
    push_exp(PC_PLUS4, 32'd0, 1'b0, 1'b0, 1'b1);
    #1 pop_cmp();
    trap_v = 1'b1; trap_a = 32'hDEAD_BEE0;
    push_exp(PC_PLUS4, 32'd0, 1'b0, 1'b0, 1'b1);
    #1 pop_cmp();
    trap_v = 1'b0; trap_a = 0;
    @(negedge clk);
    start = 1'b1;
    idle(1, 0);

    tname = "jump";
    step(0, 0, 0, 1, 32'h100, 0, 0, PC_JUMP, 32'h100, 1, 0);
    idle(1, 0);

    tname = "trap_vs_jump";
    step(0, 1, 32'h8000_0000, 1, 32'h200, 0, 0, PC_REDIR, 32'h8000_0000, 1, 0);
    idle(1, 0);

    tname = "stall_overwrite";
    step(1, 0, 0, 1, 32'h40, 0, 0, PC_PLUS4, 0, 0, 0);
    step(1, 1, 32'h180, 0, 0, 0, 0, PC_PLUS4, 0, 0, 0);
    step(1, 0, 0, 1, 32'h44, 0, 0, PC_PLUS4, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, PC_REDIR, 32'h180, 1, 0);
    idle(2, 0);

    tname = "fencei_1000";
    step(0, 0, 0, 0, 0, 1, 32'h1000, PC_PLUS4, 0, 1, 0);
    step(1, 0, 0, 1, 32'h500, 0, 0, PC_PLUS4, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 32'h2000, PC_PLUS4, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, PC_PLUS4, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, PC_PLUS4, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, PC_JUMP, 32'h1004, 1, 0);
    idle(1, 0);

    tname = "fencei_wrap";
    step(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, PC_PLUS4, 0, 1, 0);
    idle(4, 1);
    step(1, 0, 0, 0, 0, 0, 0, PC_PLUS4, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, PC_JUMP, 32'h0, 1, 0);
    idle(1, 0);

    tname = "trap_abort_drain";
    step(0, 0, 0, 0, 0, 1, 32'h1000, PC_PLUS4, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, PC_PLUS4, 0, 0, 1);
    step(0, 1, 32'h300, 0, 0, 0, 0, PC_REDIR, 32'h300, 1, 0);
    idle(6, 0);

    tname = "reset_mid_drain";
    step(0, 0, 0, 0, 0, 1, 32'h1000, PC_PLUS4, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, PC_PLUS4, 0, 0, 1);
    start = 1'b0;
    push_exp(PC_PLUS4, 32'd0, 1'b0, 1'b0, 1'b1);
    #1 pop_cmp();
    @(negedge clk);
    start = 1'b1;
    idle(7, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
